dbus_dmem_responder: RTL and testbench

- Responder end of the data-bus (dbus) interface driven by the LSU.
- Accepts load/store requests, holds a word-addressed on-chip data SRAM, and performs store byte/halfword lane merging.
- Returns a full 32-bit read word plus a one-cycle ack after a configurable number of wait states; the LSU extracts byte/halfword lanes itself.
- Sits between the core's LSU dbus port and on-chip memory; also used as the bench memory model.

---
 rtl/dbus_dmem_responder_pkg.sv | 20 ++
 rtl/dbus_dmem_responder_if.sv | 37 +++
 rtl/dbus_dmem_responder_st_merge.sv | 39 +++
 rtl/dbus_dmem_responder.sv | 142 ++++++++++++++
 tb/tb_dbus_dmem_responder.sv | 227 ++++++++++++++++++++++
 5 files changed

// File: rtl/dbus_dmem_responder_pkg.sv
// Shared types and constants for the dbus data-memory responder.
// Optional err_o reporting is enabled by defining DMEM_BUS_ERR_EN.
package dbus_dmem_responder_pkg;

  typedef enum logic [1:0] {
    ST_OPS_NONE,
    ST_OPS_SB,
    ST_OPS_SH,
    ST_OPS_SW
  } type_st_ops_e;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } type_dmem_state_e;

  localparam int DMEM_ADDR_LSB = 2;

endpackage

// File: rtl/dbus_dmem_responder_if.sv
// LSU <-> data-memory bus bundle; master is the LSU, slave is the responder.
// err_o exists only when DMEM_BUS_ERR_EN is defined.
interface dbus_dmem_responder_if import dbus_dmem_responder_pkg::*; ();

  logic [31:0]  addr_i;
  logic [31:0]  w_data_i;
  logic         ld_req_i;
  logic         st_req_i;
  type_st_ops_e st_ops_i;
  logic         lsu_flush_i;
  logic [31:0]  r_data_o;
  logic         ack_o;
`ifdef DMEM_BUS_ERR_EN
  logic         err_o;

  modport master (
    output addr_i, w_data_i, ld_req_i, st_req_i, st_ops_i, lsu_flush_i,
    input  r_data_o, ack_o, err_o
  );

  modport slave (
    input  addr_i, w_data_i, ld_req_i, st_req_i, st_ops_i, lsu_flush_i,
    output r_data_o, ack_o, err_o
  );
`else
  modport master (
    output addr_i, w_data_i, ld_req_i, st_req_i, st_ops_i, lsu_flush_i,
    input  r_data_o, ack_o
  );

  modport slave (
    input  addr_i, w_data_i, ld_req_i, st_req_i, st_ops_i, lsu_flush_i,
    output r_data_o, ack_o
  );
`endif

endinterface

// File: rtl/dbus_dmem_responder_st_merge.sv
// Store lane merge: folds byte/half/word store data into the old SRAM word.
// o_wr_vld is low for misaligned stores and for ST_OPS_NONE.
module dmem_st_merge import dbus_dmem_responder_pkg::*; (
  input  logic [31:0]  i_old_word,
  input  logic [31:0]  i_w_data,
  input  type_st_ops_e i_st_ops,
  input  logic [1:0]   i_addr_lo,
  output logic [31:0]  o_merged,
  output logic         o_wr_vld
);

  always_comb begin
    o_merged = i_old_word;
    o_wr_vld = 1'b0;
    case (i_st_ops)
      ST_OPS_SB: begin
        o_merged[{i_addr_lo, 3'b000} +: 8] = i_w_data[7:0];
        o_wr_vld = 1'b1;
      end
      ST_OPS_SH: begin
        if (!i_addr_lo[0]) begin
          o_merged[{i_addr_lo[1], 4'b0000} +: 16] = i_w_data[15:0];
          o_wr_vld = 1'b1;
        end
      end
      ST_OPS_SW: begin
        if (i_addr_lo == 2'b00) begin
          o_merged = i_w_data;
          o_wr_vld = 1'b1;
        end
      end
      default: begin
        o_merged = i_old_word;
        o_wr_vld = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/dbus_dmem_responder.sv
// Data-bus responder: word SRAM with store lane merge, WAIT_CYCLES wait states, one-cycle ack.
// Define DMEM_BUS_ERR_EN to add err_o and suppress out-of-range aliasing.
module dbus_dmem_responder import dbus_dmem_responder_pkg::*; #(
  parameter int DEPTH       = 1024,
  parameter int WAIT_CYCLES = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  dbus_dmem_responder_if.slave  bus
);

  localparam int IDX_W = $clog2(DEPTH);

  logic [31:0]      r_mem [DEPTH];

  type_dmem_state_e r_state;
  logic [3:0]       r_cnt;
  logic [31:0]      r_addr;
  logic [31:0]      r_wdata;
  type_st_ops_e     r_ops;
  logic             r_is_st;
  logic             r_ack;
  logic [31:0]      r_rdata;

  logic             w_accept;
  logic             w_go_resp;
  logic [31:0]      w_cur_addr;
  logic [31:0]      w_cur_wdata;
  type_st_ops_e     w_cur_ops;
  logic             w_cur_st;
  logic [IDX_W-1:0] w_idx;
  logic [31:0]      w_old;
  logic [31:0]      w_merged;
  logic             w_wr_vld;
  logic             w_do_wr;
  logic [31:0]      w_rd_word;

  assign w_accept  = (r_state == IDLE) && (bus.ld_req_i || bus.st_req_i) && !bus.lsu_flush_i;
  assign w_go_resp = rst_n &&
                     ((w_accept && (WAIT_CYCLES == 0)) ||
                      ((r_state == WAIT) && !bus.lsu_flush_i && (r_cnt == 4'd1)));

  // With zero wait states the SRAM is accessed on the accept edge, so bypass the latches.
  assign w_cur_addr  = (r_state == IDLE) ? bus.addr_i   : r_addr;
  assign w_cur_wdata = (r_state == IDLE) ? bus.w_data_i : r_wdata;
  assign w_cur_ops   = (r_state == IDLE) ? bus.st_ops_i : r_ops;
  assign w_cur_st    = (r_state == IDLE) ? bus.st_req_i : r_is_st;

  assign w_idx = w_cur_addr[IDX_W+1:DMEM_ADDR_LSB];
  assign w_old = r_mem[w_idx];

  dmem_st_merge u_st_merge (
    .i_old_word (w_old),
    .i_w_data   (w_cur_wdata),
    .i_st_ops   (w_cur_ops),
    .i_addr_lo  (w_cur_addr[1:0]),
    .o_merged   (w_merged),
    .o_wr_vld   (w_wr_vld)
  );

`ifdef DMEM_BUS_ERR_EN
  logic w_oor;
  logic w_err;
  logic r_err;

  assign w_oor     = (w_cur_addr[31:IDX_W+2] != '0);
  assign w_do_wr   = w_go_resp && w_cur_st && w_wr_vld && !w_oor;
  assign w_rd_word = w_oor ? 32'd0 : w_old;
  assign w_err     = w_oor || (w_cur_st && !w_wr_vld);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_err <= 1'b0;
    end else begin
      r_err <= w_go_resp ? w_err : 1'b0;
    end
  end

  assign bus.err_o = r_err;
`else
  logic w_unused_hi;

  assign w_unused_hi = ^w_cur_addr[31:IDX_W+2];
  assign w_do_wr     = w_go_resp && w_cur_st && w_wr_vld;
  assign w_rd_word   = w_old;
`endif

  always_ff @(posedge clk) begin
    if (w_do_wr) begin
      r_mem[w_idx] <= w_merged;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_cnt   <= 4'd0;
      r_ack   <= 1'b0;
      r_rdata <= 32'd0;
    end else begin
      r_ack   <= w_go_resp;
      r_rdata <= (w_go_resp && !w_cur_st) ? w_rd_word : 32'd0;
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_addr  <= bus.addr_i;
            r_wdata <= bus.w_data_i;
            r_ops   <= bus.st_ops_i;
            r_is_st <= bus.st_req_i;
            if (WAIT_CYCLES > 0) begin
              r_state <= WAIT;
              r_cnt   <= 4'(WAIT_CYCLES);
            end else begin
              r_state <= RESP;
            end
          end
        end
        WAIT: begin
          if (bus.lsu_flush_i) begin
            r_state <= IDLE;
            r_cnt   <= 4'd0;
          end else if (r_cnt == 4'd1) begin
            r_state <= RESP;
            r_cnt   <= 4'd0;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        RESP: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign bus.r_data_o = r_rdata;
  assign bus.ack_o    = r_ack;

endmodule

// File: tb/tb_dbus_dmem_responder.sv
// Scoreboard bench: one responder with zero wait states and one with three.
// Expected err_o values apply only when DMEM_BUS_ERR_EN is defined.
module tb_dbus_dmem_responder;
  import dbus_dmem_responder_pkg::*;

  typedef struct packed {
    int          cyc;
    logic [31:0] data;
    logic        err;
  } exp_t;

`ifdef DMEM_BUS_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;
  int   nvec = 0;
  int   nbad = 0;
  exp_t q0[$];
  exp_t q3[$];
  logic err0, err3;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  dbus_dmem_responder_if if0();
  dbus_dmem_responder_if if3();

  dbus_dmem_responder #(.DEPTH(1024), .WAIT_CYCLES(0)) u_dut0 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if0)
  );

  dbus_dmem_responder #(.DEPTH(1024), .WAIT_CYCLES(3)) u_dut3 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if3)
  );

`ifdef DMEM_BUS_ERR_EN
  assign err0 = if0.err_o;
  assign err3 = if3.err_o;
`else
  assign err0 = 1'b0;
  assign err3 = 1'b0;
`endif

  task automatic score(input string nm, input logic ack, input logic [31:0] rd,
                       input logic er, input bit have, input exp_t e);
    nvec++;
    if (!ack) begin
      if (rd !== 32'd0 || er !== 1'b0) begin
        nbad++;
        $display("FAIL %s idle cyc=%0d: r_data=%h err=%b, required 0 and 0", nm, cyc, rd, er);
      end
    end else if (!have) begin
      nbad++;
      $display("FAIL %s unexpected ack cyc=%0d: r_data=%h, required no ack", nm, cyc, rd);
    end else if (rd !== e.data || er !== e.err || cyc != e.cyc) begin
      nbad++;
      $display("FAIL %s ack: cyc=%0d r_data=%h err=%b, required cyc=%0d r_data=%h err=%b",
               nm, cyc, rd, er, e.cyc, e.data, e.err);
    end
  endtask

  always @(negedge clk) begin : mon0
    exp_t e0;
    bit   h0;
    e0 = '0;
    h0 = 1'b0;
    if (if0.ack_o === 1'b1 && q0.size() > 0) begin
      e0 = q0.pop_front();
      h0 = 1'b1;
    end
    score("dut0", if0.ack_o, if0.r_data_o, err0, h0, e0);
  end

  always @(negedge clk) begin : mon3
    exp_t e3;
    bit   h3;
    e3 = '0;
    h3 = 1'b0;
    if (if3.ack_o === 1'b1 && q3.size() > 0) begin
      e3 = q3.pop_front();
      h3 = 1'b1;
    end
    score("dut3", if3.ack_o, if3.r_data_o, err3, h3, e3);
  end

  task automatic drive(input int sel, input bit ld, input bit st, input logic [31:0] a,
                       input logic [31:0] d, input type_st_ops_e op);
    if (sel == 0) begin
      if0.ld_req_i = ld; if0.st_req_i = st; if0.addr_i = a; if0.w_data_i = d; if0.st_ops_i = op;
    end else begin
      if3.ld_req_i = ld; if3.st_req_i = st; if3.addr_i = a; if3.w_data_i = d; if3.st_ops_i = op;
    end
  endtask

  task automatic wait_ack(input int sel);
    bit got;
    got = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if ((sel == 0 && if0.ack_o === 1'b1) || (sel == 3 && if3.ack_o === 1'b1)) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) begin
      nvec++;
      nbad++;
      $display("FAIL dut%0d ack timeout: no ack within 40 cycles, required an ack", sel);
    end
    @(posedge clk);
    #1;
    drive(sel, 1'b0, 1'b0, 32'd0, 32'd0, ST_OPS_NONE);
  endtask

  // Called one time unit after a rising edge; the request is sampled on the next edge.
  task automatic xact(input int sel, input bit ld, input bit st, input logic [31:0] a,
                      input logic [31:0] d, input type_st_ops_e op,
                      input logic [31:0] exp_d, input bit exp_e);
    exp_t e;
    e.cyc  = cyc + 1 + ((sel == 3) ? 3 : 0);
    e.data = exp_d;
    e.err  = exp_e & ERR_EN;
    drive(sel, ld, st, a, d, op);
    if (sel == 0) q0.push_back(e);
    else          q3.push_back(e);
    wait_ack(sel);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1);
  end

  initial begin
    exp_t e;
    rst_n = 1'b0;
    drive(0, 1'b0, 1'b0, 32'd0, 32'd0, ST_OPS_NONE);
    drive(3, 1'b0, 1'b0, 32'd0, 32'd0, ST_OPS_NONE);
    if0.lsu_flush_i = 1'b0;
    if3.lsu_flush_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Zero-wait-state responder
    xact(0, 0, 1, 32'h10, 32'hDEADBEEF, ST_OPS_SW, 32'h0, 0);
    xact(0, 1, 0, 32'h10, 32'h0, ST_OPS_NONE, 32'hDEADBEEF, 0);
    xact(0, 0, 1, 32'h20, 32'h0, ST_OPS_SW, 32'h0, 0);
    xact(0, 0, 1, 32'h23, 32'h555555AB, ST_OPS_SB, 32'h0, 0);
    xact(0, 0, 1, 32'h20, 32'hAAAA1234, ST_OPS_SH, 32'h0, 0);
    xact(0, 1, 0, 32'h20, 32'h0, ST_OPS_NONE, 32'hAB001234, 0);
    xact(0, 1, 0, 32'h22, 32'h0, ST_OPS_NONE, 32'hAB001234, 0);
    xact(0, 0, 1, 32'h21, 32'h12345677, ST_OPS_SB, 32'h0, 0);
    xact(0, 0, 1, 32'h22, 32'h1111BEEF, ST_OPS_SH, 32'h0, 0);
    xact(0, 1, 0, 32'h20, 32'h0, ST_OPS_NONE, 32'hBEEF7734, 0);
    xact(0, 0, 1, 32'h30, 32'h11223344, ST_OPS_SW, 32'h0, 0);
    xact(0, 0, 1, 32'h31, 32'hFFFFFFFF, ST_OPS_SH, 32'h0, 1);
    xact(0, 0, 1, 32'h40, 32'h55667788, ST_OPS_SW, 32'h0, 0);
    xact(0, 0, 1, 32'h42, 32'hFFFFFFFF, ST_OPS_SW, 32'h0, 1);
    xact(0, 1, 0, 32'h30, 32'h0, ST_OPS_NONE, 32'h11223344, 0);
    xact(0, 1, 0, 32'h40, 32'h0, ST_OPS_NONE, 32'h55667788, 0);
    xact(0, 0, 1, 32'h30, 32'hFFFFFFFF, ST_OPS_NONE, 32'h0, 1);
    xact(0, 1, 0, 32'h30, 32'h0, ST_OPS_NONE, 32'h11223344, 0);
    xact(0, 1, 1, 32'h50, 32'hCAFEF00D, ST_OPS_SW, 32'h0, 0);
    xact(0, 1, 0, 32'h50, 32'h0, ST_OPS_NONE, 32'hCAFEF00D, 0);
    xact(0, 0, 1, 32'h0, 32'h01010101, ST_OPS_SW, 32'h0, 0);
    xact(0, 0, 1, 32'h1000, 32'h02020202, ST_OPS_SW, 32'h0, 1);
    xact(0, 1, 0, 32'h0, 32'h0, ST_OPS_NONE, ERR_EN ? 32'h01010101 : 32'h02020202, 0);
    xact(0, 1, 0, 32'h1000, 32'h0, ST_OPS_NONE, ERR_EN ? 32'h0 : 32'h02020202, 1);

    // Three-wait-state responder
    xact(3, 0, 1, 32'h10, 32'h13579BDF, ST_OPS_SW, 32'h0, 0);
    xact(3, 1, 0, 32'h10, 32'h0, ST_OPS_NONE, 32'h13579BDF, 0);

    // Flush a store while it waits: no ack, no write
    drive(3, 1'b0, 1'b1, 32'h10, 32'hFFFFFFFF, ST_OPS_SW);
    @(posedge clk);
    #1;
    if3.lsu_flush_i = 1'b1;
    @(posedge clk);
    #1;
    if3.lsu_flush_i = 1'b0;
    drive(3, 1'b0, 1'b0, 32'd0, 32'd0, ST_OPS_NONE);
    repeat (6) @(posedge clk);
    #1;
    xact(3, 1, 0, 32'h10, 32'h0, ST_OPS_NONE, 32'h13579BDF, 0);

    // Reset during WAIT while the load stays held; it is re-accepted afterwards
    drive(3, 1'b1, 1'b0, 32'h10, 32'h0, ST_OPS_NONE);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    e.cyc  = cyc + 1 + 3;
    e.data = 32'h13579BDF;
    e.err  = 1'b0;
    q3.push_back(e);
    wait_ack(3);

    repeat (6) @(posedge clk);
    #1;
    nvec++;
    if (q0.size() != 0 || q3.size() != 0) begin
      nbad++;
      $display("FAIL pending: dut0 left %0d dut3 left %0d expected acks, required 0", q0.size(), q3.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
    $finish;
  end

endmodule
